// File: rtl/banked_data_mem.sv
`default_nettype none
// ============================================================================
// Module      : banked_data_mem
// Description : Single-port data memory for the MEM stage. Requests use a
//               valid/ready handshake. Writes are masked per lane. Reads
//               return a registered response one cycle after acceptance.
//               Requests to addresses at or beyond DEPTH are flagged on
//               reads and dropped on writes.
//
//               Optional feature macro: BANKED_MEM_CLEAR_EN
//                 When this macro is defined, a clear engine zeroes one word
//                 per cycle after every reset. Requests are held off until
//                 every word is zero.
//                 When it is undefined, the memory is ready one edge after
//                 reset and keeps its contents across reset.
//
// Ports       : clk        - clock, rising edge
//               reset      - asynchronous reset, active low
//               req_valid  - request present
//               req_ready  - request can be accepted this cycle
//               req_write  - 1 = write, 0 = read
//               req_addr   - word address
//               req_wdata  - write data
//               req_wmask  - per-lane write enable
//               rsp_valid  - one-cycle pulse per accepted read
//               rsp_rdata  - read data (holds while rsp_valid = 0)
//               rsp_err    - accepted read was out of range
//               busy       - clear engine active
//
// Revision    : 1.0 - initial release
// ============================================================================
module banked_data_mem #(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 2**ADDR_WIDTH,
    parameter int DATA_WIDTH = 16,
    parameter int LANE_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [DATA_WIDTH-1:0]            req_wdata,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0] req_wmask,
    output logic                             rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic                             busy
);

    localparam int c_NUM_LANES = DATA_WIDTH / LANE_WIDTH;
    // Array index width: just wide enough to address DEPTH words.
    localparam int c_IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // ------------------------------------------------------------------------
    // Storage (not reset; contents survive reset unless cleared)
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  r_ready;
    logic                  w_accept;
    logic                  w_in_range;
    logic [c_IDX_W-1:0]    w_idx;
    logic [DATA_WIDTH-1:0] w_cur_word;
    logic [DATA_WIDTH-1:0] w_merged;
    logic                  w_acc_wr;

    logic                  w_mem_we;
    logic [c_IDX_W-1:0]    w_mem_idx;
    logic [DATA_WIDTH-1:0] w_mem_wdata;

    assign w_accept   = req_valid & r_ready;
    assign w_in_range = ({1'b0, req_addr} < (ADDR_WIDTH+1)'(DEPTH));
    assign w_idx      = req_addr[c_IDX_W-1:0];
    assign w_cur_word = r_mem[w_idx];
    // An out-of-range write is accepted but must not touch the array.
    assign w_acc_wr   = w_accept & req_write & w_in_range;

    // Lanes that are not enabled keep the current word value, so a masked
    // write is a read-merge-write of a single word.
    for (genvar g = 0; g < c_NUM_LANES; g++) begin : g_lane
        assign w_merged[g*LANE_WIDTH +: LANE_WIDTH] =
            req_wmask[g] ? req_wdata[g*LANE_WIDTH +: LANE_WIDTH]
                         : w_cur_word[g*LANE_WIDTH +: LANE_WIDTH];
    end

`ifdef BANKED_MEM_CLEAR_EN
    // ------------------------------------------------------------------------
    // Clear engine: CLEAR zeroes one word per edge, then READY forever
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(DEPTH - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [c_IDX_W-1:0] r_clr_ptr;
    logic [c_IDX_W-1:0] w_clr_ptr_next;
    logic               w_clr_we;
    logic               r_busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= CLEAR;
            r_clr_ptr <= '0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_clr_ptr <= w_clr_ptr_next;
            // Ready/busy are registered from the next state, so they flip
            // right after the edge that clears the last word.
            r_ready   <= (w_state_next == READY);
            r_busy    <= (w_state_next == CLEAR);
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_clr_ptr_next = r_clr_ptr;
        w_clr_we       = 1'b0;
        case (r_state)
            CLEAR: begin
                w_clr_we       = 1'b1;
                w_clr_ptr_next = r_clr_ptr + c_IDX_W'(1);
                if (r_clr_ptr == c_LAST) begin
                    w_state_next = READY;
                end
            end
            READY: begin
                w_state_next = READY;
            end
            default: begin
                w_state_next = CLEAR;
            end
        endcase
    end

    // No request can be accepted while clearing, so the two writers never
    // collide.
    assign w_mem_we    = w_clr_we | w_acc_wr;
    assign w_mem_idx   = w_clr_we ? r_clr_ptr : w_idx;
    assign w_mem_wdata = w_clr_we ? '0 : w_merged;
    assign busy        = r_busy;
`else
    // ------------------------------------------------------------------------
    // No clear engine: ready one edge after reset release
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= 1'b1;
        end
    end

    assign w_mem_we    = w_acc_wr;
    assign w_mem_idx   = w_idx;
    assign w_mem_wdata = w_merged;
    assign busy        = 1'b0;
`endif

    assign req_ready = r_ready;

    // ------------------------------------------------------------------------
    // Array write port
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_idx] <= w_mem_wdata;
        end
    end

    // ------------------------------------------------------------------------
    // Registered read response; data and error hold between pulses
    // ------------------------------------------------------------------------
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else if (w_accept && !req_write) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_in_range ? w_cur_word : '0;
            r_rsp_err   <= ~w_in_range;
        end else begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_banked_data_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_banked_data_mem
// Description : Self-checking bench for banked_data_mem (DEPTH = 200).
//               A behavioural model counts edges since reset release and
//               keeps a word array. It is compared with the DUT on every
//               falling edge. Directed checks use literal values.
//               Expectations follow BANKED_MEM_CLEAR_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_banked_data_mem;

    localparam int AW    = 8;
    localparam int DEPTH = 200;
    localparam int DW    = 16;
    localparam int LW    = 8;
    localparam int NL    = DW / LW;
`ifdef BANKED_MEM_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif
    // Edges after reset release before the first request can be accepted.
    localparam int LAT = CLR ? DEPTH : 1;

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [NL-1:0] req_wmask;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          busy;

    banked_data_mem #(
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DW),
        .LANE_WIDTH (LW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------------
    logic [DW-1:0] mdl   [256];
    bit            known [256];
    int            edges;
    logic          e_ready, e_busy, e_valid, e_err;
    logic [DW-1:0] e_rdata;
    bit            e_rknown;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            edges    = 0;
            e_ready  = 1'b0;
            e_busy   = CLR;
            e_valid  = 1'b0;
            e_err    = 1'b0;
            e_rdata  = '0;
            e_rknown = 1'b1;
            if (CLR) begin
                for (int i = 0; i < 256; i++) begin
                    mdl[i]   = '0;
                    known[i] = (i < DEPTH);
                end
            end
        end else begin
            e_valid = 1'b0;
            if (req_valid && edges >= LAT) begin
                if (req_write) begin
                    if (int'(req_addr) < DEPTH) begin
                        for (int l = 0; l < NL; l++)
                            if (req_wmask[l]) mdl[req_addr][l*LW +: LW] = req_wdata[l*LW +: LW];
                        if (req_wmask == '1) known[req_addr] = 1'b1;
                    end
                end else begin
                    e_valid = 1'b1;
                    if (int'(req_addr) < DEPTH) begin
                        e_rdata  = mdl[req_addr];
                        e_err    = 1'b0;
                        e_rknown = known[req_addr];
                    end else begin
                        e_rdata  = '0;
                        e_err    = 1'b1;
                        e_rknown = 1'b1;
                    end
                end
            end
            edges++;
            e_ready = (edges >= LAT);
            e_busy  = CLR && (edges < DEPTH);
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("m_ready", 32'(req_ready), 32'(e_ready));
            chk("m_busy",  32'(busy),      32'(e_busy));
            chk("m_valid", 32'(rsp_valid), 32'(e_valid));
            chk("m_err",   32'(rsp_err),   32'(e_err));
            if (e_rknown) chk("m_rdata", 32'(rsp_rdata), 32'(e_rdata));
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic issue(input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [NL-1:0] m);
        bit done;
        done      = 1'b0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        req_wmask = m;
        for (int n = 0; n < 1000 && !done; n++) begin
            if (req_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) chk("issue_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [AW-1:0] a,
                            input logic [DW-1:0] exp, input logic experr, input bit cdata);
        issue(1'b0, a, '0, '0);
        @(negedge clk);
        chk({name, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({name, "_err"},   32'(rsp_err),   32'(experr));
        if (cdata) chk({name, "_data"}, 32'(rsp_rdata), 32'(exp));
    endtask

    // ------------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------------
    initial begin
        int n;
        for (int i = 0; i < 256; i++) known[i] = 1'b0;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_on = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_busy",  32'(busy),      32'(CLR));
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", 32'(rsp_rdata), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // 1: edge counting after release
        for (int k = 1; k <= LAT; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("t1_ready", 32'(req_ready), 32'(k >= LAT));
            chk("t1_busy",  32'(busy),      32'(CLR && k < DEPTH));
        end
        read_chk("t1_r0",   8'd0,   16'h0000, 1'b0, CLR);
        read_chk("t1_r100", 8'd100, 16'h0000, 1'b0, CLR);
        read_chk("t1_r199", 8'd199, 16'h0000, 1'b0, CLR);

        // 2: full write then read
        issue(1'b1, 8'd5, 16'hABCD, 2'b11);
        read_chk("t2", 8'd5, 16'hABCD, 1'b0, 1'b1);

        // 3: lane masking
        issue(1'b1, 8'd5, 16'h1234, 2'b01);
        read_chk("t3a", 8'd5, 16'hAB34, 1'b0, 1'b1);
        issue(1'b1, 8'd5, 16'hFFFF, 2'b00);
        read_chk("t3b", 8'd5, 16'hAB34, 1'b0, 1'b1);

        // 4: out of range
        issue(1'b1, 8'd210, 16'h5555, 2'b11);
        read_chk("t4a", 8'd210, 16'h0000, 1'b1, 1'b1);
        read_chk("t4b", 8'd199, 16'h0000, 1'b0, CLR);

        // 5: back-to-back reads
        issue(1'b1, 8'd1, 16'h0001, 2'b11);
        issue(1'b1, 8'd2, 16'h0002, 2'b11);
        issue(1'b1, 8'd3, 16'h0003, 2'b11);
        chk("t5_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'd3;
        @(posedge clk); #1 req_addr = 8'd1;
        @(negedge clk);
        chk("t5_v0", 32'(rsp_valid), 32'd1);
        chk("t5_d0", 32'(rsp_rdata), 32'h0003);
        @(posedge clk); #1 req_addr = 8'd2;
        @(negedge clk);
        chk("t5_v1", 32'(rsp_valid), 32'd1);
        chk("t5_d1", 32'(rsp_rdata), 32'h0001);
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        chk("t5_v2", 32'(rsp_valid), 32'd1);
        chk("t5_d2", 32'(rsp_rdata), 32'h0002);
        @(posedge clk); #1;

        // Randomized traffic with idle gaps
        for (int r = 0; r < 400; r++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            issue(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0) ? AW'($urandom_range(DEPTH, 255))
                                              : AW'($urandom_range(0, DEPTH - 1)),
                  DW'($urandom), NL'($urandom));
        end

        // 6: reset during clear, then reset with a read in flight
        @(posedge clk); #1 reset = 1'b0;
        #1 chk("t6_rst_valid", 32'(rsp_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (50) @(posedge clk);
        #1 reset = 1'b0;
        #1 chk("t6_mid_ready", 32'(req_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        // Presented during clear; must be held until accepted.
        issue(1'b1, 8'd7, 16'hBEEF, 2'b11);
        read_chk("t6_rd7", 8'd7, 16'hBEEF, 1'b0, 1'b1);
        issue(1'b0, 8'd7, '0, '0);
        chk("t6_inflight", 32'(rsp_valid), 32'd1);
        reset = 1'b0;
        #1;
        chk("t6_async_valid", 32'(rsp_valid), 32'd0);
        chk("t6_async_rdata", 32'(rsp_rdata), 32'd0);
        chk("t6_async_err",   32'(rsp_err),   32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        n = 0;
        while (!req_ready && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t6_latency", 32'(n), 32'(LAT));
        if (CLR) begin
            read_chk("t6_z5", 8'd5, 16'h0000, 1'b0, 1'b1);
            read_chk("t6_z7", 8'd7, 16'h0000, 1'b0, 1'b1);
            read_chk("t6_z1", 8'd1, 16'h0000, 1'b0, 1'b1);
            read_chk("t6_z3", 8'd3, 16'h0000, 1'b0, 1'b1);
        end else begin
            read_chk("t6_keep7", 8'd7, 16'hBEEF, 1'b0, 1'b1);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/banked_data_mem.md
# banked_data_mem

Parametrised single-port data memory for the pipeline's MEM stage. Adds per-lane write masking, a registered one-cycle read response, a valid/ready request handshake, non-power-of-two depth with out-of-range detection, and an optional sequential clear engine that zeroes the array after reset. The array is cleared one word per cycle rather than in a single cycle.

## Interface
- `ADDR_WIDTH`, 8: request address width.
- `DEPTH`, 2**ADDR_WIDTH: number of words. Must satisfy 1 ≤ DEPTH ≤ 2**ADDR_WIDTH.
- `DATA_WIDTH`, 16: word width. Must be a multiple of LANE_WIDTH.
- `LANE_WIDTH`, 8: width of one write-mask lane. NUM_LANES = DATA_WIDTH/LANE_WIDTH.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  memory can accept a request this cycle.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_WIDTH  word address.
- `req_wdata`  in  DATA_WIDTH  write data.
- `req_wmask`  in  NUM_LANES  per-lane write enable; bit i covers lane i, bits [i*LANE_WIDTH +: LANE_WIDTH].
- `rsp_valid`  out  1  read response valid, one-cycle pulse per accepted read.
- `rsp_rdata`  out  DATA_WIDTH  read data.
- `rsp_err`  out  1  the accepted read addressed a word at or beyond DEPTH.
- `busy`  out  1  clear engine active.

## Operation
- A request is accepted on a rising edge where req_valid=1 and req_ready=1. At most one request is accepted per cycle.
- Accepted write, in range: lane i of mem[req_addr] takes lane i of req_wdata iff req_wmask[i]=1. Other lanes keep their values. A write with wmask=0 is accepted and has no effect.
- Accepted write, out of range (req_addr ≥ DEPTH): dropped silently. The array is unchanged and no response is produced.
- Accepted read produces exactly one response; writes produce none.
  - In range: rsp_rdata = mem[req_addr], rsp_err=0.
  - Out of range: rsp_rdata = 0, rsp_err=1.
- The response has no backpressure.
- rsp_rdata and rsp_err hold their last value while rsp_valid=0.
- The array itself is not reset. Only the control registers are reset.
- State machine, two states:
  - CLEAR: busy=1, req_ready=0. Pointer clr_ptr starts at 0 and writes mem[clr_ptr]=0 each edge, incrementing. On the edge that writes DEPTH-1, the block moves to READY.
  - READY: busy=0, req_ready=1. The block stays in READY until reset.
- Reset asserted, at any time including mid-clear or with a read in flight:
  - state goes to CLEAR (or READY without the macro) and clr_ptr to 0;
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=1 (busy=0 without the macro);
  - any pending response is discarded.
  - req_ready is held 0 while reset is low, regardless of state.

## Timing
- Read accepted at edge N: rsp_valid=1 with its data during the cycle after edge N. rsp_valid deasserts at edge N+1 unless another read was accepted at N+1.
- Back-to-back reads give back-to-back responses, in request order, at full throughput.
- Write accepted at edge N: visible to a read accepted at edge N+1 or later.
- With clear enabled:
  - the first edge after reset release clears word 0;
  - req_ready and ~busy rise after edge DEPTH (registered);
  - the first request can be accepted at edge DEPTH+1.
- Without clear: req_ready rises after the first edge following reset release.
- A request presented while req_ready=0 is not accepted. The requester must hold it until it is accepted.

## Configuration
- Macro `BANKED_MEM_CLEAR_EN`.
- Defined: after every reset the CLEAR state runs for DEPTH cycles, and all words read 0x0 afterwards.
- Undefined: the CLEAR state, clr_ptr and clear logic are compiled out.
  - Reset enters READY directly and busy is tied 0.
  - Array contents after reset are those from before reset (X at power-up).
  - Handshake and response timing are otherwise identical.

## Test plan
Parameters for all scenarios: DEPTH=200, ADDR_WIDTH=8, DATA_WIDTH=16, LANE_WIDTH=8, clear enabled.

1. Release reset and count edges → busy=1 and req_ready=0 for edges 1–199. req_ready=1 and busy=0 after edge 200. Reads of addresses 0, 100 and 199 return 0x0000 with rsp_err=0.
2. Write 0xABCD to addr 5 with wmask=2'b11, then read addr 5 on the next cycle → rsp_valid=1 one cycle after the read is accepted, rsp_rdata=0xABCD.
3. Write 0x1234 to addr 5 with wmask=2'b01, then read addr 5 → 0xAB34. Write with wmask=2'b00, then read → still 0xAB34.
4. Write 0x5555 to addr 210, then read addr 210 → rsp_err=1, rsp_rdata=0x0000. A read of addr 199 afterwards returns 0x0000 with rsp_err=0.
5. Write 0x0001, 0x0002 and 0x0003 to addrs 1–3, then read addrs 3, 1, 2 on consecutive cycles → rsp_valid high for 3 consecutive cycles with data 0x0003, 0x0001, 0x0002.
6. Assert reset at clear cycle 50, release, then later assert reset again in the cycle after a read is accepted.
   - rsp_valid goes to 0 asynchronously.
   - req_ready rises only after 200 edges following the final release.
   - All previously written words read 0x0000.
